// File: rtl/vliw_hazard_ctrl.sv
// vliw_hazard_ctrl: forwarding selects, load-use stall, branch flush and memory-wait freeze
// for the two-lane ALU+MEM VLIW pipeline, tracking EX/MEM and MEM/WB destinations in shadows.
module vliw_hazard_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [2:0] id_alu_rn,
    input  logic [2:0] id_alu_rm,
    input  logic [2:0] id_mem_rn,
    input  logic [2:0] id_mem_rd,
    input  logic       id_alu_rm_used,
    input  logic       id_mem_rd_used,
    input  logic       p2_valid,
    input  logic [2:0] p2_alu_rn,
    input  logic [2:0] p2_alu_rm,
    input  logic [2:0] p2_alu_rd,
    input  logic [2:0] p2_mem_rn,
    input  logic [2:0] p2_mem_rd,
    input  logic       p2_alu_regWrite,
    input  logic       p2_mem_regWrite,
    input  logic       p2_memRead,
    input  logic       p2_memWrite,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       p3_pipeline_regWrite,
    output logic       EX_flush,
    output logic       mem_wb_write,
    output logic [1:0] f_alu_reg_rn_sel,
    output logic [1:0] f_alu_reg_rm_sel,
    output logic [1:0] f_mem_reg_rn_sel,
    output logic       f_mem_reg_rd_sel
);
    localparam int CW = $clog2(MEM_WAIT + 2);

    typedef enum logic {RUN, WAIT} state_t;
    typedef struct packed {
        logic [2:0] alu_rd;
        logic       alu_w;
        logic [2:0] mem_rd;
        logic       mem_w;
    } wr_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    wr_t           p2_wr, s3_wr, s3_wr_d, s4;
    logic          p2_memop, s3_memop, s3_memop_d;
    logic          run, hazard, branch, stall;

    function automatic logic [1:0] fwd(input logic [2:0] s, input wr_t a, input wr_t b);
        return (a.alu_w && a.alu_rd == s && !(a.mem_w && a.mem_rd == s)) ? 2'd1 :
               (b.mem_w && b.mem_rd == s) ? 2'd3 :
               (b.alu_w && b.alu_rd == s) ? 2'd2 : 2'd0;
    endfunction

    assign run    = state == RUN;
    assign hazard = id_valid && p2_valid && p2_mem_regWrite &&
                    (p2_mem_rd == id_alu_rn || (id_alu_rm_used && p2_mem_rd == id_alu_rm) ||
                     p2_mem_rd == id_mem_rn || (id_mem_rd_used && p2_mem_rd == id_mem_rd));
    assign branch = !reset && run && ex_branch_taken;
    assign stall  = !reset && run && !ex_branch_taken && hazard;

    assign pc_write             = run && !stall;
    assign if_id_write          = run && !stall;
    assign id_ex_write          = run;
    assign id_ex_flush          = branch || stall;
    assign p3_pipeline_regWrite = run;
    assign mem_wb_write         = run;
    assign EX_flush             = stall && !p3_pipeline_regWrite;

    assign f_alu_reg_rn_sel = fwd(p2_alu_rn, s3_wr, s4);
    assign f_alu_reg_rm_sel = fwd(p2_alu_rm, s3_wr, s4);
    assign f_mem_reg_rn_sel = fwd(p2_mem_rn, s3_wr, s4);
    assign f_mem_reg_rd_sel = (s4.alu_w && s4.alu_rd == p2_mem_rd) || (s4.mem_w && s4.mem_rd == p2_mem_rd);

    assign p2_wr      = {p2_alu_rd, p2_valid & p2_alu_regWrite, p2_mem_rd, p2_valid & p2_mem_regWrite};
    assign p2_memop   = p2_valid & (p2_memRead | p2_memWrite);
    assign s3_wr_d    = !p3_pipeline_regWrite ? s3_wr : EX_flush ? '0 : p2_wr;
    assign s3_memop_d = !p3_pipeline_regWrite ? s3_memop : !EX_flush && p2_memop;

    // The wait starts on the edge that captures the memop into EX/MEM, so the op
    // sits in MEM for exactly 1 + MEM_WAIT cycles and is not re-detected on release.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (run) begin
            if (MEM_WAIT > 0 && s3_memop_d) begin
                state_nx = WAIT;
                cnt_nx   = CW'(MEM_WAIT);
            end
        end else begin
            cnt_nx   = cnt - CW'(1);
            state_nx = cnt == CW'(1) ? RUN : WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            s3_wr    <= '0;
            s3_memop <= 1'b0;
            s4       <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            s3_wr    <= s3_wr_d;
            s3_memop <= s3_memop_d;
            if (mem_wb_write) s4 <= s3_wr;
        end
    end
endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// tb_vliw_hazard_ctrl: directed pipeline scenarios for vliw_hazard_ctrl (MEM_WAIT=2) with
// per-cycle expectations queued at drive time and compared at the following negedge.
module tb_vliw_hazard_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic       id_valid, id_alu_rm_used, id_mem_rd_used;
    logic [2:0] id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd;
    logic       p2_valid, p2_alu_regWrite, p2_mem_regWrite, p2_memRead, p2_memWrite;
    logic [2:0] p2_alu_rn, p2_alu_rm, p2_alu_rd, p2_mem_rn, p2_mem_rd;
    logic       ex_branch_taken;
    logic       pc_write, if_id_write, id_ex_write, id_ex_flush, p3_pipeline_regWrite, EX_flush, mem_wb_write;
    logic [1:0] f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
    logic       f_mem_reg_rd_sel;

    // {pc_write, if_id_write, id_ex_write, id_ex_flush, p3_pipeline_regWrite, EX_flush, mem_wb_write}
    localparam logic [6:0] RUNC  = 7'b1110101;
    localparam logic [6:0] STALL = 7'b0011101;
    localparam logic [6:0] BR    = 7'b1111101;
    localparam logic [6:0] FRZ   = 7'b0000000;

    int          n_tests = 0, n_fail = 0;
    logic [13:0] exp_q[$];
    string       tag_q[$];
    logic [13:0] e_cur;
    string       t_cur;

    vliw_hazard_ctrl #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_alu_rn(id_alu_rn), .id_alu_rm(id_alu_rm),
        .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd),
        .id_alu_rm_used(id_alu_rm_used), .id_mem_rd_used(id_mem_rd_used),
        .p2_valid(p2_valid), .p2_alu_rn(p2_alu_rn), .p2_alu_rm(p2_alu_rm), .p2_alu_rd(p2_alu_rd),
        .p2_mem_rn(p2_mem_rn), .p2_mem_rd(p2_mem_rd),
        .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
        .p2_memRead(p2_memRead), .p2_memWrite(p2_memWrite),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .id_ex_flush(id_ex_flush), .p3_pipeline_regWrite(p3_pipeline_regWrite),
        .EX_flush(EX_flush), .mem_wb_write(mem_wb_write),
        .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
        .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            t_cur = tag_q.pop_front();
            check({t_cur, "_ctrl"},
                  {pc_write, if_id_write, id_ex_write, id_ex_flush, p3_pipeline_regWrite, EX_flush, mem_wb_write},
                  e_cur[13:7]);
            check({t_cur, "_sel"},
                  {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel},
                  e_cur[6:0]);
        end
    end

    task automatic clr();
        {id_valid, id_alu_rm_used, id_mem_rd_used, id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd} = '0;
        {p2_valid, p2_alu_regWrite, p2_mem_regWrite, p2_memRead, p2_memWrite} = '0;
        {p2_alu_rn, p2_alu_rm, p2_alu_rd, p2_mem_rn, p2_mem_rd} = '0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic p2_set(input logic v, input logic [2:0] arn, arm, ard, mrn, mrd,
                          input logic aw, mw, mr, mwr);
        p2_valid = v; p2_alu_rn = arn; p2_alu_rm = arm; p2_alu_rd = ard;
        p2_mem_rn = mrn; p2_mem_rd = mrd;
        p2_alu_regWrite = aw; p2_mem_regWrite = mw; p2_memRead = mr; p2_memWrite = mwr;
    endtask

    task automatic id_set(input logic v, input logic [2:0] arn, arm, mrn, mrd, input logic rmu, rdu);
        id_valid = v; id_alu_rn = arn; id_alu_rm = arm; id_mem_rn = mrn; id_mem_rd = mrd;
        id_alu_rm_used = rmu; id_mem_rd_used = rdu;
    endtask

    task automatic step(input string tag, input logic [6:0] ctrl, input logic [6:0] sel);
        exp_q.push_back({ctrl, sel});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr();
        @(posedge clk);
        #1;
        step("reset", RUNC, 7'b0000000);
        reset = 1'b0;
        // ALU result forwarded from EX/MEM, then MEM/WB, then regfile
        p2_set(1, 0,0,1,0,0, 1,0,0,0);  step("alu_wr",   RUNC, 7'b0000000);
        clr(); p2_set(1, 1,0,0,0,0, 0,0,0,0); step("fwd_ex",   RUNC, 7'b0100000);
        step("fwd_wb",   RUNC, 7'b1000000);
        step("fwd_none", RUNC, 7'b0000000);
        // both lanes write r2 with a load: two freeze cycles, then MEM lane wins
        clr(); p2_set(1, 0,0,2,0,2, 1,1,1,0); step("dual_wr",   RUNC, 7'b0000000);
        step("dual_frz1", FRZ,  7'b0000000);
        step("dual_frz2", FRZ,  7'b0000000);
        clr(); step("dual_rel", RUNC, 7'b0000000);
        p2_set(1, 2,0,0,0,2, 0,0,0,0);        step("dual_fwd",  RUNC, 7'b1100001);
        // load r3 consumed as alu_rm: one bubble, load waits, then sel 3
        clr(); p2_set(1, 0,0,0,0,3, 0,1,1,0); id_set(1, 0,3,0,0, 1,0);
        step("lu_stall", STALL, 7'b0000000);
        clr(); id_set(1, 0,3,0,0, 1,0);
        step("lu_frz1", FRZ,  7'b0000000);
        step("lu_frz2", FRZ,  7'b0000000);
        step("lu_bub",  RUNC, 7'b0000000);
        clr(); p2_set(1, 0,3,0,0,0, 0,0,0,0); step("lu_fwd",  RUNC, 7'b0011000);
        // store freeze with a pending load-use: no flush while frozen
        clr(); p2_set(1, 0,0,0,0,5, 0,0,0,1); step("st",       RUNC, 7'b0000000);
        clr(); p2_set(1, 0,0,0,0,4, 0,1,1,0); id_set(1, 0,0,4,0, 0,0);
        step("st_frz1_lu", FRZ,   7'b0000000);
        step("st_frz2_lu", FRZ,   7'b0000000);
        step("st_rel_lu",  STALL, 7'b0000000);
        clr(); id_set(1, 0,0,4,0, 0,0);
        step("ld4_frz1", FRZ,  7'b0000000);
        step("ld4_frz2", FRZ,  7'b0000000);
        step("ld4_bub",  RUNC, 7'b0000000);
        clr(); p2_set(1, 0,0,0,4,0, 0,0,0,0); step("ld4_fwd", RUNC, 7'b0000110);
        // branch beats a simultaneous load-use
        clr(); p2_set(1, 0,0,0,0,6, 0,1,1,0); id_set(1, 6,0,0,0, 0,0); ex_branch_taken = 1'b1;
        step("br_lu", BR, 7'b0000000);
        clr(); id_set(1, 0,0,0,0, 0,0);
        step("brlu_frz1", FRZ,  7'b0000000);
        step("brlu_frz2", FRZ,  7'b0000000);
        step("brlu_bub",  RUNC, 7'b0000000);
        // branch held through a freeze acts on the first RUN cycle
        clr(); p2_set(1, 6,0,7,0,0, 1,0,0,1); step("st_r7", RUNC, 7'b1100000);
        clr(); p2_set(1, 7,0,0,0,0, 0,0,0,0); ex_branch_taken = 1'b1;
        step("br_frz1", FRZ, 7'b0100000);
        step("br_frz2", FRZ, 7'b0100000);
        step("br_held", BR,  7'b0100000);
        clr(); step("br_after", RUNC, 7'b0000000);
        // reset in the last wait cycle aborts the wait and clears the shadows
        p2_set(1, 0,0,7,0,0, 1,0,0,0);        step("pre_rst_wr", RUNC, 7'b0000000);
        clr(); p2_set(1, 7,0,0,0,0, 0,0,0,1); step("pre_rst_st", RUNC, 7'b0100000);
        step("rst_frz1", FRZ, 7'b1000000);
        #1 reset = 1'b1;
        step("rst_mid_wait", RUNC, 7'b0000000);
        reset = 1'b0;
        step("rst_rel", RUNC, 7'b0000000);
        check("drain", 7'(exp_q.size()), 7'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
